// File: rtl/ifetch_prefetch_pkg.sv
// +----------------------------------------------------------------------------+
// | ifetch_prefetch_pkg : shared word/address types and the prefetch entry      |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

package ifetch_prefetch_pkg;

  localparam int NB_WORD = 32;
  localparam int NB_ADDR = 32;

  typedef logic [NB_WORD-1:0] instruction_t;

  localparam instruction_t RV_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [NB_WORD-1:0] pc;
    instruction_t       instr;
  } fetch_entry_t;

endpackage

`default_nettype wire

// File: rtl/ifetch_prefetch_fifo.sv
// +----------------------------------------------------------------------------+
// | sync_fifo : synchronous FIFO with push/pop/clear, head data and fill count  |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clear_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] data_o,
  output logic [CW-1:0]    count_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q,  count_d;

  // Pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [AW-1:0] ptr_incr(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = ptr_incr(wr_ptr_q);
      if (pop_i)  rd_ptr_d = ptr_incr(rd_ptr_q);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_i && !clear_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/ifetch_prefetch.sv
// +----------------------------------------------------------------------------+
// | ifetch_prefetch : in-order instruction fetch with credit-limited prefetch   |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module ifetch_prefetch
  import ifetch_prefetch_pkg::*;
#(
  parameter int                 QUEUE_DEPTH     = 4,
  parameter int                 MAX_OUTSTANDING = 2,
  parameter logic [NB_ADDR-1:0] RESET_PC        = 32'h0000_0000
) (
  input  logic               i_clock,
  input  logic               i_reset,
  output logic               o_imem_req_valid,
  input  logic               i_imem_req_ready,
  output logic [NB_ADDR-1:0] o_imem_req_addr,
  input  logic               i_imem_rsp_valid,
  input  logic [NB_WORD-1:0] i_imem_rsp_data,
  input  logic               i_stall,
  input  logic               i_redirect,
  input  logic [NB_ADDR-1:0] i_redirect_addr,
  output logic               o_valid,
  output logic [NB_WORD-1:0] o_instruction,
  output logic [NB_WORD-1:0] o_pc
);

  localparam int QCW = $clog2(QUEUE_DEPTH + 1);
  localparam int OCW = $clog2(MAX_OUTSTANDING + 1);

  logic [NB_ADDR-1:0] fetch_pc_q, fetch_pc_d;
  logic [OCW-1:0]     drop_cnt_q, drop_cnt_d;
  logic [OCW-1:0]     outstanding;
  logic [QCW-1:0]     q_count;
  logic [NB_ADDR-1:0] inflight_pc;
  fetch_entry_t       q_head, q_wdata;
  logic               rsp_fire, accept, q_push, q_pop;
  int                 credit_used;

  // In-flight occupancy doubles as the outstanding-request counter.
  sync_fifo #(
    .WIDTH (NB_ADDR),
    .DEPTH (MAX_OUTSTANDING)
  ) u_inflight (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .clear_i (1'b0),
    .push_i  (accept),
    .data_i  (fetch_pc_q),
    .pop_i   (rsp_fire),
    .data_o  (inflight_pc),
    .count_o (outstanding)
  );

  sync_fifo #(
    .WIDTH ($bits(fetch_entry_t)),
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk_i   (i_clock),
    .rst_i   (i_reset),
    .clear_i (i_redirect),
    .push_i  (q_push),
    .data_i  (q_wdata),
    .pop_i   (q_pop),
    .data_o  (q_head),
    .count_o (q_count)
  );

  always_comb begin
    credit_used      = int'(q_count) + int'(outstanding) - int'(drop_cnt_q);
    o_imem_req_valid = !i_reset && !i_redirect
                       && (int'(outstanding) < MAX_OUTSTANDING)
                       && (credit_used < QUEUE_DEPTH);
    accept   = o_imem_req_valid && i_imem_req_ready;
    rsp_fire = i_imem_rsp_valid && !i_reset;
    q_push   = rsp_fire && !i_redirect && (drop_cnt_q == '0);
    q_pop    = o_valid && !i_stall && !i_redirect;
    q_wdata  = '{pc: NB_WORD'(inflight_pc), instr: i_imem_rsp_data};
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    drop_cnt_d = drop_cnt_q;
    if (i_redirect) begin
      fetch_pc_d = {i_redirect_addr[NB_ADDR-1:2], 2'b00};
      drop_cnt_d = outstanding - OCW'(rsp_fire);
    end else begin
      if (accept) fetch_pc_d = fetch_pc_q + NB_ADDR'(4);
      if (rsp_fire && (drop_cnt_q != '0)) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      fetch_pc_q <= RESET_PC;
      drop_cnt_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign o_imem_req_addr = fetch_pc_q;
  assign o_valid         = (q_count != '0);
  assign o_instruction   = o_valid ? q_head.instr : RV_NOP;
  assign o_pc            = o_valid ? q_head.pc : '0;

  a_no_orphan_rsp: assert property (@(posedge i_clock) disable iff (i_reset)
    i_imem_rsp_valid |-> (outstanding != '0));
  a_queue_bound: assert property (@(posedge i_clock)
    int'(q_count) <= QUEUE_DEPTH);

endmodule

`default_nettype wire

// File: tb/tb_ifetch_prefetch.sv
// +----------------------------------------------------------------------------+
// | tb_ifetch_prefetch : queue-level model plus directed fetch scenarios        |
// | Rev 1.0                                                                     |
// +----------------------------------------------------------------------------+
`default_nettype none

module tb_ifetch_prefetch;

  localparam int          QD  = 4;
  localparam int          MO  = 2;
  localparam logic [31:0] RPC = 32'h0000_0000;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        i_reset, i_imem_req_ready, i_imem_rsp_valid, i_stall, i_redirect;
  logic [31:0] i_imem_rsp_data, i_redirect_addr;
  logic        o_imem_req_valid, o_valid;
  logic [31:0] o_imem_req_addr, o_instruction, o_pc;

  ifetch_prefetch #(.QUEUE_DEPTH(QD), .MAX_OUTSTANDING(MO), .RESET_PC(RPC)) dut (
    .i_clock          (clk),
    .i_reset          (i_reset),
    .o_imem_req_valid (o_imem_req_valid),
    .i_imem_req_ready (i_imem_req_ready),
    .o_imem_req_addr  (o_imem_req_addr),
    .i_imem_rsp_valid (i_imem_rsp_valid),
    .i_imem_rsp_data  (i_imem_rsp_data),
    .i_stall          (i_stall),
    .i_redirect       (i_redirect),
    .i_redirect_addr  (i_redirect_addr),
    .o_valid          (o_valid),
    .o_instruction    (o_instruction),
    .o_pc             (o_pc)
  );

  typedef struct { logic [31:0] pc; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; int due; } pend_t;

  ent_t        mq[$];
  pend_t       pend[$];
  logic [31:0] log_pc[$];
  int          drop, cyc, vectors, miscompares;
  logic [31:0] fexp, first_acc;
  bit          got_acc;

  bit          rst_s, stall_s, redir_s, ready_s, rand_ready;
  logic [31:0] raddr_s;
  int          lat_lo, lat_hi;
  bit          s_req_valid, s_o_valid;
  logic [31:0] s_o_pc, s_o_ins;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_log(input string name, input int idx, input logic [31:0] exp);
    if (idx < log_pc.size()) check(name, log_pc[idx], exp);
    else check(name, 32'hxxxx_xxxx, exp);
  endtask

  // One cycle: drive at negedge, compare against the queue model, advance it.
  task automatic step();
    bit          exp_rv, acc, rsp;
    logic [31:0] ra;
    @(negedge clk);
    i_reset         = rst_s;
    i_stall         = stall_s;
    i_redirect      = redir_s;
    i_redirect_addr = raddr_s;
    i_imem_req_ready = rand_ready ? 1'($urandom_range(0, 1)) : ready_s;
    rsp = !rst_s && pend.size() > 0 && pend[0].due <= cyc;
    i_imem_rsp_valid = rsp;
    i_imem_rsp_data  = rsp ? mem_word(pend[0].addr) : $urandom;
    #1;
    s_req_valid = o_imem_req_valid;
    s_o_valid   = o_valid;
    s_o_pc      = o_pc;
    s_o_ins     = o_instruction;
    if (rst_s) begin
      pend.delete(); mq.delete(); log_pc.delete();
      drop = 0; fexp = RPC; got_acc = 0;
    end else begin
      exp_rv = !redir_s && pend.size() < MO && (mq.size() + pend.size() - drop) < QD;
      check("req_valid", 32'(o_imem_req_valid), 32'(exp_rv));
      if (o_imem_req_valid) check("req_addr", o_imem_req_addr, fexp);
      check("o_valid", 32'(o_valid), 32'(mq.size() > 0));
      if (mq.size() > 0) begin
        check("o_pc", o_pc, mq[0].pc);
        check("o_instruction", o_instruction, mq[0].ins);
      end else begin
        check("o_pc_bubble", o_pc, 32'h0);
        check("o_instruction_bubble", o_instruction, NOP);
      end
      acc = o_imem_req_valid && i_imem_req_ready;
      ra  = 32'h0;
      if (rsp) begin ra = pend[0].addr; pend.pop_front(); end
      if (redir_s) begin
        mq.delete(); log_pc.delete();
        drop = pend.size();
        fexp = {raddr_s[31:2], 2'b00};
        got_acc = 0;
      end else begin
        if (mq.size() > 0 && !stall_s) begin log_pc.push_back(mq[0].pc); mq.pop_front(); end
        if (rsp) begin
          if (drop > 0) drop--;
          else mq.push_back('{ra, mem_word(ra)});
        end
      end
      if (acc) begin
        if (!got_acc) begin first_acc = fexp; got_acc = 1; end
        pend.push_back('{fexp, cyc + $urandom_range(lat_lo, lat_hi)});
        fexp += 32'd4;
      end
    end
    cyc++;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0; drop = 0; fexp = RPC; got_acc = 0;
    rst_s = 1; stall_s = 0; redir_s = 0; raddr_s = 0; ready_s = 1; rand_ready = 0;
    lat_lo = 1; lat_hi = 1;

    repeat (2) step();
    check("rst_o_valid", 32'(s_o_valid), 32'h0);
    check("rst_o_instruction", s_o_ins, NOP);
    check("rst_o_pc", s_o_pc, 32'h0);
    check("rst_req_valid", 32'(s_req_valid), 32'h0);
    rst_s = 0;

    // Streaming
    repeat (8) step();
    check_log("stream_pc0", 0, 32'h0);
    check_log("stream_pc1", 1, 32'h4);
    check_log("stream_pc2", 2, 32'h8);
    check_log("stream_pc3", 3, 32'hC);

    // Stall until the queue is full
    stall_s = 1;
    repeat (10) step();
    check("stall_qfill", 32'(mq.size()), 32'd4);
    check("stall_req_valid", 32'(s_req_valid), 32'h0);
    check("stall_head_pc", s_o_pc, 32'h18);
    stall_s = 0;
    log_pc.delete();
    repeat (10) step();
    check_log("release_pc0", 0, 32'h18);
    for (int i = 1; i < log_pc.size(); i++)
      check("release_seq", log_pc[i], log_pc[i-1] + 32'd4);

    // Redirect with two requests in flight
    lat_lo = 3; lat_hi = 3;
    repeat (3) step();
    check("inflight_before_redirect", 32'(pend.size()), 32'd2);
    redir_s = 1; raddr_s = 32'h100;
    step();
    redir_s = 0; lat_lo = 1; lat_hi = 1;
    repeat (10) step();
    check("redir_first_req", first_acc, 32'h100);
    check_log("redir_first_pc", 0, 32'h100);

    // Redirect under stall with a same-cycle response
    repeat (3) step();
    stall_s = 1; redir_s = 1; raddr_s = 32'h200;
    step();
    stall_s = 0; redir_s = 0;
    repeat (8) step();
    check_log("redir_stall_pc", 0, 32'h200);

    // Misaligned target and address wrap
    redir_s = 1; raddr_s = 32'h103;
    step();
    redir_s = 0;
    repeat (6) step();
    check("align_first_req", first_acc, 32'h100);
    check_log("align_first_pc", 0, 32'h100);
    redir_s = 1; raddr_s = 32'hFFFF_FFFC;
    step();
    redir_s = 0;
    repeat (8) step();
    check_log("wrap_pc0", 0, 32'hFFFF_FFFC);
    check_log("wrap_pc1", 1, 32'h0);
    check_log("wrap_pc2", 2, 32'h4);

    // Random backpressure, variable latency, sporadic stalls
    rand_ready = 1; lat_lo = 1; lat_hi = 3;
    for (int i = 0; i < 200; i++) begin
      stall_s = ($urandom_range(0, 3) == 0);
      step();
    end
    stall_s = 0;

    // Reset mid-stream
    rst_s = 1;
    repeat (2) step();
    check("midrst_o_valid", 32'(s_o_valid), 32'h0);
    check("midrst_req_valid", 32'(s_req_valid), 32'h0);
    rst_s = 0; rand_ready = 0; ready_s = 1; lat_lo = 1; lat_hi = 1;
    repeat (4) step();
    check("midrst_first_req", got_acc ? first_acc : 32'hxxxx_xxxx, RPC);
    check_log("midrst_first_pc", 0, RPC);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
